// File: rtl/trace_logger_mc.sv
// Trace/stream logger between a tracer and a time-multiplexed trace RAM.
// Optional build macro LOGGER_DROP_COUNT_EN enables the saturating drop counter on DROP_CNT_O.
module trace_logger_mc #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 256,
    parameter int DELAY_BITS = 3,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  CLK_I,
    input  logic                  RST_NI,
    input  logic                  MODE_I,
    input  logic [DELAY_BITS-1:0] TRG_DELAY_I,
    input  logic                  CLEAR_I,
    input  logic                  RW_TURN_I,
    input  logic                  WRITE_ALLOW_I,
    input  logic                  READ_ALLOW_I,
    output logic                  WRITE_O,
    output logic [ADDR_W-1:0]     WRITE_PTR_O,
    output logic [DATA_W-1:0]     DMEM_O,
    output logic [ADDR_W-1:0]     READ_PTR_O,
    input  logic [DATA_W-1:0]     DMEM_I,
    input  logic                  STORE_I,
    input  logic [DATA_W-1:0]     DATA_I,
    output logic                  STORE_PERM_O,
    input  logic                  LOAD_REQUEST_I,
    output logic                  LOAD_GRANT_O,
    output logic [DATA_W-1:0]     DATA_O,
    input  logic                  TRG_EVENT_I,
    output logic                  TRG_DELAYED_O,
    output logic [ADDR_W-1:0]     EVENT_ADDR_O,
    output logic [ADDR_W:0]       FILL_O,
    output logic [15:0]           DROP_CNT_O
);

    localparam int LEN_W = ADDR_W + DELAY_BITS + 1;
    localparam logic [ADDR_W:0]   FILL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   FILL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        DELAY  = 2'd1,
        FROZEN = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   hist, hist_nxt;
    logic [ADDR_W-1:0]   event_addr, event_addr_nxt;

    logic                mode_q, mode_locked, mode_eff;
    logic                pending, pending_rd;
    logic [DATA_W-1:0]   dmem;
    logic [DATA_W-1:0]   data_q;
    logic                grant;
    logic [ADDR_W-1:0]   write_ptr, read_ptr;
    logic [ADDR_W:0]     fill;
    logic                wr_fire, rd_fire, trace_full;

    // Post-trigger history length: ((d+1)*(DEPTH-1)) >> DELAY_BITS, always below DEPTH.
    function automatic logic [ADDR_W-1:0] post_len(input logic [DELAY_BITS-1:0] d);
        logic [LEN_W-1:0] prod;
        prod = (LEN_W'(d) + LEN_W'(1)) * LEN_W'(DEPTH - 1);
        prod = prod >> DELAY_BITS;
        return prod[ADDR_W-1:0];
    endfunction

    // Mode is captured on the first clock after reset or at CLEAR_I, then held.
    assign mode_eff   = mode_locked ? mode_q : MODE_I;
    assign trace_full = !mode_eff && (fill == FILL_FULL);
    assign wr_fire    = !CLEAR_I && pending && RW_TURN_I && WRITE_ALLOW_I &&
                        (state != FROZEN) && (!mode_eff || (fill != FILL_FULL));
    assign rd_fire    = !CLEAR_I && !RW_TURN_I && READ_ALLOW_I && pending_rd &&
                        (fill != '0);

    assign WRITE_O       = wr_fire;
    assign STORE_PERM_O  = RST_NI && !CLEAR_I && (!pending || wr_fire);
    assign WRITE_PTR_O   = write_ptr;
    assign READ_PTR_O    = read_ptr;
    assign DMEM_O        = dmem;
    assign DATA_O        = data_q;
    assign LOAD_GRANT_O  = grant;
    assign FILL_O        = fill;
    assign EVENT_ADDR_O  = event_addr;
    assign TRG_DELAYED_O = (state == FROZEN);

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            mode_q      <= 1'b0;
            mode_locked <= 1'b0;
            pending     <= 1'b0;
            pending_rd  <= 1'b0;
            dmem        <= '0;
            data_q      <= '0;
            grant       <= 1'b0;
            write_ptr   <= '0;
            read_ptr    <= '0;
            fill        <= '0;
        end else if (CLEAR_I) begin
            mode_q      <= MODE_I;
            mode_locked <= 1'b1;
            pending     <= 1'b0;
            pending_rd  <= 1'b0;
            dmem        <= '0;
            data_q      <= '0;
            grant       <= 1'b0;
            write_ptr   <= '0;
            read_ptr    <= '0;
            fill        <= '0;
        end else begin
            if (!mode_locked) begin
                mode_q      <= MODE_I;
                mode_locked <= 1'b1;
            end
            if (STORE_I) begin
                dmem <= DATA_I;
            end
            pending    <= STORE_I || (pending && !wr_fire);
            pending_rd <= LOAD_REQUEST_I || (pending_rd && !rd_fire);
            grant      <= rd_fire;
            if (wr_fire) begin
                write_ptr <= write_ptr + PTR_ONE;
                // A full trace ring overwrites its oldest entry instead of growing.
                if (trace_full) begin
                    read_ptr <= read_ptr + PTR_ONE;
                end else begin
                    fill <= fill + FILL_ONE;
                end
            end
            if (rd_fire) begin
                data_q   <= DMEM_I;
                read_ptr <= read_ptr + PTR_ONE;
                fill     <= fill - FILL_ONE;
            end
        end
    end

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            state      <= ARMED;
            hist       <= '0;
            event_addr <= '0;
        end else if (CLEAR_I) begin
            state      <= ARMED;
            hist       <= '0;
            event_addr <= '0;
        end else begin
            state      <= state_nxt;
            hist       <= hist_nxt;
            event_addr <= event_addr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        hist_nxt       = hist;
        event_addr_nxt = event_addr;
        case (state)
            ARMED: begin
                if (!mode_eff && TRG_EVENT_I) begin
                    state_nxt      = DELAY;
                    event_addr_nxt = write_ptr;
                    hist_nxt       = post_len(TRG_DELAY_I);
                end
            end
            DELAY: begin
                // The write that finds hist at zero is the last one before freezing.
                if (wr_fire) begin
                    if (hist != '0) begin
                        hist_nxt = hist - PTR_ONE;
                    end else begin
                        state_nxt = FROZEN;
                    end
                end
            end
            FROZEN: begin
                state_nxt = FROZEN;
            end
            default: begin
                state_nxt = ARMED;
            end
        endcase
    end

`ifdef LOGGER_DROP_COUNT_EN
    logic        drop;
    logic [15:0] drop_cnt;

    assign drop = STORE_I && pending && !wr_fire;

    always_ff @(posedge CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            drop_cnt <= '0;
        end else if (CLEAR_I) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign DROP_CNT_O = drop_cnt;
`else
    assign DROP_CNT_O = '0;
`endif

endmodule

// File: tb/tb_trace_logger_mc.sv
// Directed bench for trace_logger_mc (DEPTH=8, DATA_W=16) with a behavioural RAM on the memory port.
module tb_trace_logger_mc;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode;
    logic [2:0]    trg_delay;
    logic          clear;
    logic          rw_turn;
    logic          write_allow;
    logic          read_allow;
    logic          write;
    logic [AW-1:0] write_ptr;
    logic [DW-1:0] dmem_out;
    logic [AW-1:0] read_ptr;
    logic [DW-1:0] dmem_in;
    logic          store;
    logic [DW-1:0] data_in;
    logic          store_perm;
    logic          load_request;
    logic          load_grant;
    logic [DW-1:0] data_out;
    logic          trg_event;
    logic          trg_delayed;
    logic [AW-1:0] event_addr;
    logic [AW:0]   fill;
    logic [15:0]   drop_cnt;

    logic [DW-1:0] mem [0:7];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            wr_seen = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (write) mem[write_ptr] <= dmem_out;
    assign dmem_in = mem[read_ptr];

    trace_logger_mc #(.DATA_W(DW), .DEPTH(8), .DELAY_BITS(3)) dut (
        .CLK_I(clk), .RST_NI(rst_n), .MODE_I(mode), .TRG_DELAY_I(trg_delay),
        .CLEAR_I(clear), .RW_TURN_I(rw_turn), .WRITE_ALLOW_I(write_allow),
        .READ_ALLOW_I(read_allow), .WRITE_O(write), .WRITE_PTR_O(write_ptr),
        .DMEM_O(dmem_out), .READ_PTR_O(read_ptr), .DMEM_I(dmem_in),
        .STORE_I(store), .DATA_I(data_in), .STORE_PERM_O(store_perm),
        .LOAD_REQUEST_I(load_request), .LOAD_GRANT_O(load_grant), .DATA_O(data_out),
        .TRG_EVENT_I(trg_event), .TRG_DELAYED_O(trg_delayed),
        .EVENT_ADDR_O(event_addr), .FILL_O(fill), .DROP_CNT_O(drop_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One store followed by one write slot; write pulses are tallied in wr_seen.
    task automatic store_slot(input logic [DW-1:0] w);
        store = 1'b1; data_in = w; rw_turn = 1'b0;
        tick();
        store = 1'b0; rw_turn = 1'b1;
        #1;
        if (write) wr_seen++;
        tick();
        rw_turn = 1'b0;
    endtask

    task automatic do_clear(input logic m);
        mode = m; clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; trg_delay = 3'd0; clear = 1'b0; rw_turn = 1'b0;
        write_allow = 1'b1; read_allow = 1'b1; store = 1'b0; data_in = '0;
        load_request = 1'b0; trg_event = 1'b0;
        #1;
        chk("rst_store_perm", store_perm, 0);
        chk("rst_fill", fill, 0);
        chk("rst_write", write, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_store_perm", store_perm, 1);
        chk("post_rst_trg_delayed", trg_delayed, 0);

        // Trace mode, delay 0: trigger after 10 stores, exactly one more write.
        for (int i = 1; i <= 10; i++) store_slot(DW'(i));
        chk("t1_fill_full", fill, 8);
        trg_event = 1'b1;
        tick();
        trg_event = 1'b0;
        chk("t1_event_addr", event_addr, 2);
        chk("t1_not_frozen_yet", trg_delayed, 0);
        wr_seen = 0;
        for (int i = 11; i <= 20; i++) store_slot(DW'(i));
        chk("t1_post_writes", wr_seen, 1);
        chk("t1_frozen", trg_delayed, 1);
        chk("t1_write_ptr", write_ptr, 3);
        chk("t1_read_ptr", read_ptr, 3);
        chk("t1_fill", fill, 8);
        chk("t1_dmem_last", dmem_out, 20);
`ifdef LOGGER_DROP_COUNT_EN
        chk("t1_drops", drop_cnt, 8);
`else
        chk("t1_drops", drop_cnt, 0);
`endif
        rw_turn = 1'b1;
        #1;
        chk("t1_write_blocked", write, 0);
        chk("t1_perm_blocked", store_perm, 0);
        load_request = 1'b1;
        tick();
        load_request = 1'b0; rw_turn = 1'b0;
        tick();
        chk("t1_grant", load_grant, 1);
        chk("t1_oldest", data_out, 4);
        chk("t1_fill_after_rd", fill, 7);
        rw_turn = 1'b1;
        tick();
        chk("t1_grant_pulse", load_grant, 0);

        // Trace mode, delay 6 gives L=6: seven writes after the trigger.
        rw_turn = 1'b0;
        do_clear(1'b0);
        chk("t2_clear_fill", fill, 0);
        chk("t2_clear_frozen", trg_delayed, 0);
        chk("t2_clear_event", event_addr, 0);
        chk("t2_clear_dmem", dmem_out, 0);
        chk("t2_clear_drop", drop_cnt, 0);
        trg_delay = 3'd6;
        for (int i = 1; i <= 3; i++) store_slot(DW'(16'h100 + i));
        trg_event = 1'b1;
        tick();
        trg_event = 1'b0;
        chk("t2_event_addr", event_addr, 3);
        wr_seen = 0;
        for (int i = 4; i <= 12; i++) store_slot(DW'(16'h100 + i));
        chk("t2_post_writes", wr_seen, 7);
        chk("t2_frozen", trg_delayed, 1);
        chk("t2_write_ptr", write_ptr, 2);

        // Stream mode: full FIFO stalls the ninth word until a read frees space.
        trg_delay = 3'd0;
        do_clear(1'b1);
        mode = 1'b0;
        wr_seen = 0;
        for (int i = 1; i <= 9; i++) store_slot(DW'(16'h200 + i));
        chk("t3_writes", wr_seen, 8);
        chk("t3_fill", fill, 8);
        rw_turn = 1'b1;
        #1;
        chk("t3_perm_full", store_perm, 0);
        chk("t3_write_stall", write, 0);
        chk("t3_held_word", dmem_out, 16'h209);
        trg_event = 1'b1; load_request = 1'b1;
        tick();
        trg_event = 1'b0; load_request = 1'b0; rw_turn = 1'b0;
        tick();
        chk("t3_grant", load_grant, 1);
        chk("t3_data", data_out, 16'h201);
        chk("t3_fill_rd", fill, 7);
        rw_turn = 1'b1;
        #1;
        chk("t3_write_resume", write, 1);
        tick();
        rw_turn = 1'b0;
        chk("t3_fill_back", fill, 8);
        chk("t3_write_ptr", write_ptr, 1);
        chk("t3_perm_back", store_perm, 1);
        chk("t3_trigger_ignored", trg_delayed, 0);

        // Back-to-back stores without a write slot lose the first word.
        do_clear(1'b0);
        store = 1'b1; data_in = 16'hAAAA;
        tick();
        data_in = 16'hBBBB;
        tick();
        store = 1'b0;
        chk("t4_dmem", dmem_out, 16'hBBBB);
`ifdef LOGGER_DROP_COUNT_EN
        chk("t4_drop", drop_cnt, 1);
`else
        chk("t4_drop", drop_cnt, 0);
`endif

        // Read request on an empty buffer waits for data.
        do_clear(1'b0);
        load_request = 1'b1;
        tick();
        load_request = 1'b0;
        tick();
        chk("t5_no_grant_empty", load_grant, 0);
        store_slot(16'h5A5A);
        chk("t5_no_grant_yet", load_grant, 0);
        tick();
        chk("t5_grant", load_grant, 1);
        chk("t5_data", data_out, 16'h5A5A);
        chk("t5_fill", fill, 0);

        // Asynchronous reset with a pending word and fill=5.
        do_clear(1'b0);
        for (int i = 1; i <= 5; i++) store_slot(DW'(16'h300 + i));
        store = 1'b1; data_in = 16'h1234;
        tick();
        store = 1'b0; rw_turn = 1'b1;
        #1;
        chk("t6_fill_before", fill, 5);
        chk("t6_write_armed", write, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_write", write, 0);
        chk("t6_rst_perm", store_perm, 0);
        chk("t6_rst_fill", fill, 0);
        chk("t6_rst_wptr", write_ptr, 0);
        chk("t6_rst_dmem", dmem_out, 0);
        rw_turn = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_fill_after", fill, 0);
        chk("t6_perm_after", store_perm, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
